// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: frame FSM state encoding, GRB packing and
// cycle-count helpers used by both the frame sequencer and the bit engine.
package ws2812_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SCALE,
      ST_LOAD,
      ST_WAIT,
      ST_LATCH,
      ST_DONE
   } state_t;

   // WS2812 shifts green first, then red, then blue
   function automatic logic [23:0] grb_pack(input logic [7:0] r,
                                            input logic [7:0] g,
                                            input logic [7:0] b);
      return {g, r, b};
   endfunction

   function automatic int treset_cycles(input int f_clk, input int us);
      longint t;
      t = (longint'(us) * longint'(f_clk)) / longint'(1_000_000);
      return int'(t);
   endfunction

   function automatic int refresh_period(input int f_clk, input int hz);
      return f_clk / hz;
   endfunction

endpackage

// File: rtl/ws2812_frame_sequencer_if.sv
// Word handshake between the frame sequencer (master) and the bit-timing engine (slave).
interface ws2812_frame_sequencer_if;
   logic [23:0] tx_data;
   logic        tx_load;
   logic        tx_done;

   modport master (output tx_data, output tx_load, input tx_done);
   modport slave  (input tx_data, input tx_load, output tx_done);
endinterface

// File: rtl/ws2812_pixel_ram.sv
// Pixel store: synchronous write port, registered read port (read-before-write).
module ws2812_pixel_ram #(
   parameter int NUM_LEDS = 16,
   parameter int ADDR_W   = 4
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [23:0]       i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [23:0]       o_rd_data
);

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(NUM_LEDS);

   logic [23:0] r_mem [2**ADDR_W];
   logic [23:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en && ({1'b0, i_wr_addr} < DEPTH)) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Frame-level WS2812 controller: fetches pixels, scales by brightness, hands GRB
// words to the bit engine, then times the latch gap.
//
//   state | meaning
//   IDLE  | waiting for Start / refresh tick / pending request
//   FETCH | pixel RAM addressed with current index
//   SCALE | brightness applied, GRB word registered
//   LOAD  | TxLoad pulse to bit engine
//   WAIT  | waiting for TxDone of current word
//   LATCH | line held low for the reset/latch gap
//   DONE  | FrameDone pulse, back to IDLE
module ws2812_frame_sequencer
   import ws2812_pkg::*;
#(
   parameter int F_CLK      = 12_000_000,
   parameter int NUM_LEDS   = 16,
   parameter int ADDR_W     = 4,
   parameter int TRESET_US  = 60,
   parameter int REFRESH_HZ = 30
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_wr_en,
   input  logic [ADDR_W-1:0]    i_wr_addr,
   input  logic [23:0]          i_wr_data,
   input  logic [7:0]           i_brightness,
   input  logic                 i_start,
   input  logic                 i_auto_refresh,
   ws2812_frame_sequencer_if.master tx,
   output logic                 o_latch_active,
   output logic                 o_busy,
   output logic                 o_frame_done,
   output logic [ADDR_W-1:0]    o_pixel_index
);

   localparam int TRESET         = treset_cycles(F_CLK, TRESET_US);
   localparam int REFRESH_PERIOD = refresh_period(F_CLK, REFRESH_HZ);
   localparam int LAT_W          = $clog2(TRESET + 1);
   localparam int REF_W          = $clog2(REFRESH_PERIOD + 1);
   localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(TRESET - 1);
   localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REFRESH_PERIOD - 1);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_LEDS - 1);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_idx;
   logic [7:0]        r_bright;
   logic              r_pending;
   logic [LAT_W-1:0]  r_lat_cnt;
   logic [REF_W-1:0]  r_ref_cnt;
   logic [23:0]       r_tx_data;
   logic [23:0]       w_ram_rd;
   logic              w_tick;
   logic              w_req;
   logic              w_last;
   logic [8:0]        w_gain;
   logic [7:0]        w_r;
   logic [7:0]        w_g;
   logic [7:0]        w_b;

   function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [8:0] gain);
      logic [15:0] p;
      p = {8'b0, c} * {7'b0, gain};
      return 8'(p >> 8);
   endfunction

   ws2812_pixel_ram #(
      .NUM_LEDS (NUM_LEDS),
      .ADDR_W   (ADDR_W)
   ) u_ram (
      .i_clk     (i_clk),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_rd_addr (r_idx),
      .o_rd_data (w_ram_rd)
   );

   assign w_tick = i_auto_refresh && (r_ref_cnt == REF_LAST);
   assign w_req  = i_start | w_tick | r_pending;
   assign w_last = (r_idx == IDX_LAST);
   assign w_gain = {1'b0, r_bright} + 9'd1;
   assign w_r    = scale_ch(w_ram_rd[23:16], w_gain);
   assign w_g    = scale_ch(w_ram_rd[15:8], w_gain);
   assign w_b    = scale_ch(w_ram_rd[7:0], w_gain);

   always_ff @(posedge i_clk) begin
      if (i_rst || !i_auto_refresh) begin
         r_ref_cnt <= '0;
      end else if (r_ref_cnt == REF_LAST) begin
         r_ref_cnt <= '0;
      end else begin
         r_ref_cnt <= r_ref_cnt + REF_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next         = r_state;
      tx.tx_load     = 1'b0;
      tx.tx_data     = r_tx_data;
      o_latch_active = 1'b0;
      o_frame_done   = 1'b0;
      o_busy         = (r_state != ST_IDLE);
      o_pixel_index  = r_idx;
      case (r_state)
         ST_IDLE:  if (w_req) w_next = ST_FETCH;
         ST_FETCH: w_next = ST_SCALE;
         ST_SCALE: w_next = ST_LOAD;
         ST_LOAD: begin
            tx.tx_load = 1'b1;
            w_next     = ST_WAIT;
         end
         ST_WAIT:  if (tx.tx_done) w_next = w_last ? ST_LATCH : ST_FETCH;
         ST_LATCH: begin
            o_latch_active = 1'b1;
            if (r_lat_cnt == '0) w_next = ST_DONE;
         end
         ST_DONE: begin
            o_frame_done = 1'b1;
            w_next       = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // At most one request is queued while a frame is running
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pending <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_pending <= 1'b0;
      end else if (i_start || w_tick) begin
         r_pending <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idx     <= '0;
         r_bright  <= '0;
         r_lat_cnt <= '0;
         r_tx_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_idx    <= '0;
                  r_bright <= i_brightness;
               end
            end
            ST_SCALE: r_tx_data <= grb_pack(w_r, w_g, w_b);
            ST_WAIT: begin
               if (tx.tx_done) begin
                  if (w_last) r_lat_cnt <= LAT_LOAD;
                  else        r_idx     <= r_idx + ADDR_W'(1);
               end
            end
            ST_LATCH: if (r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench for ws2812_frame_sequencer: instance A (default timing, 5-bit address)
// and instance B (1000-cycle auto-refresh period), each with a behavioural bit-engine responder.
module tb_ws2812_frame_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic        rst_a = 1'b1, rst_b = 1'b1;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [23:0] wr_data = '0;
   logic [7:0]  bright = 8'd255;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic        auto_a = 1'b0, auto_b = 1'b0;
   logic        busy_a, latch_a, done_a, busy_b, latch_b, done_b;
   logic [4:0]  pidx_a;
   logic [3:0]  pidx_b;
   logic        wr_en_b;
   logic        resp_a = 1'b0, spur_a = 1'b0, resp_b = 1'b0;
   bit          resp_en_a = 1'b1;

   ws2812_frame_sequencer_if ifa ();
   ws2812_frame_sequencer_if ifb ();
   assign ifa.tx_done = resp_a | spur_a;
   assign ifb.tx_done = resp_b;
   assign wr_en_b     = wr_en & ~wr_addr[4];

   ws2812_frame_sequencer #(.NUM_LEDS(16), .ADDR_W(5)) dut_a (
      .i_clk(clk), .i_rst(rst_a), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_brightness(bright), .i_start(start_a), .i_auto_refresh(auto_a), .tx(ifa),
      .o_latch_active(latch_a), .o_busy(busy_a), .o_frame_done(done_a), .o_pixel_index(pidx_a));

   ws2812_frame_sequencer #(.REFRESH_HZ(12_000)) dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_wr_en(wr_en_b), .i_wr_addr(wr_addr[3:0]), .i_wr_data(wr_data),
      .i_brightness(bright), .i_start(start_b), .i_auto_refresh(auto_b), .tx(ifb),
      .o_latch_active(latch_b), .o_busy(busy_b), .o_frame_done(done_b), .o_pixel_index(pidx_b));

   // Monitors + bit-engine responders: TxDone one cycle after each TxLoad
   int          n_load_a = 0, n_latch_a = 0, n_done_a = 0, done_cyc_a = 0, rcnt_a = 0;
   logic [23:0] ld_data_a [256];
   int          ld_cyc_a  [256];
   logic [4:0]  ld_idx_a  [256];
   int          n_load_b = 0, n_done_b = 0, rcnt_b = 0;
   int          ld_cyc_b  [256];

   always @(negedge clk) begin
      resp_a = 1'b0;
      if (rcnt_a > 0) begin
         rcnt_a--;
         if (rcnt_a == 0 && resp_en_a) resp_a = 1'b1;
      end
      if (ifa.tx_load === 1'b1) begin
         if (n_load_a < 256) begin
            ld_data_a[n_load_a] = ifa.tx_data;
            ld_cyc_a[n_load_a]  = cyc;
            ld_idx_a[n_load_a]  = pidx_a;
         end
         n_load_a++;
         rcnt_a = 1;
      end
      if (latch_a === 1'b1) n_latch_a++;
      if (done_a === 1'b1) begin
         n_done_a++;
         done_cyc_a = cyc;
      end
   end

   always @(negedge clk) begin
      resp_b = 1'b0;
      if (rcnt_b > 0) begin
         rcnt_b--;
         if (rcnt_b == 0) resp_b = 1'b1;
      end
      if (ifb.tx_load === 1'b1) begin
         if (n_load_b < 256) ld_cyc_b[n_load_b] = cyc;
         n_load_b++;
         rcnt_b = 1;
      end
      if (done_b === 1'b1) n_done_b++;
   end

   logic [23:0] pix [16];

   function automatic logic [23:0] exp_grb(input logic [23:0] p, input int br);
      int r, g, b;
      r = (int'(p[23:16]) * (br + 1)) >> 8;
      g = (int'(p[15:8])  * (br + 1)) >> 8;
      b = (int'(p[7:0])   * (br + 1)) >> 8;
      return {8'(g), 8'(r), 8'(b)};
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic write_pix(input logic [4:0] a, input logic [23:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic pulse_start_a(output int c);
      start_a = 1'b1;
      c = cyc;
      step();
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input int base, input int limit);
      for (int i = 0; i < limit && n_done_a == base; i++) step();
      checks++;
      if (n_done_a == base) begin
         errors++;
         $display("FAIL wait_done_a: frame_done count %0d, required above %0d within %0d cycles", n_done_a, base, limit);
      end
   endtask

   task automatic wait_loads_a(input int target, input int limit);
      for (int i = 0; i < limit && n_load_a < target; i++) step();
      checks++;
      if (n_load_a < target) begin
         errors++;
         $display("FAIL wait_loads_a: load count %0d, required %0d", n_load_a, target);
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      steps(3);
      checks++; if (ifa.tx_load !== 1'b0) begin errors++; $display("FAIL reset_tx_load got %b exp 0", ifa.tx_load); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
      checks++; if (latch_a !== 1'b0) begin errors++; $display("FAIL reset_latch got %b exp 0", latch_a); end
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", done_a); end
      checks++; if (pidx_a !== 5'd0) begin errors++; $display("FAIL reset_pixel_index got %0d exp 0", pidx_a); end
      checks++; if (ifa.tx_data !== 24'h0) begin errors++; $display("FAIL reset_tx_data got %h exp 000000", ifa.tx_data); end
      checks++; if (busy_b !== 1'b0 || ifb.tx_load !== 1'b0) begin errors++; $display("FAIL reset_b busy %b load %b exp 0 0", busy_b, ifb.tx_load); end
      rst_a = 1'b0; rst_b = 1'b0;
      step();
   endtask

   task automatic test_frame();
      int c, b, lb, db;
      bright = 8'd255;
      b = n_load_a; lb = n_latch_a; db = n_done_a;
      pulse_start_a(c);
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL frame_busy_rise got %b exp 1", busy_a); end
      wait_done_a(db, 2000);
      checks++; if (ld_cyc_a[b] - c != 3) begin errors++; $display("FAIL frame_first_load_latency got %0d exp 3", ld_cyc_a[b] - c); end
      checks++; if (ld_data_a[b] !== 24'h80FF01) begin errors++; $display("FAIL frame_pixel0 got %h exp 80ff01", ld_data_a[b]); end
      checks++; if (ld_cyc_a[b+1] - ld_cyc_a[b] != 4) begin errors++; $display("FAIL frame_load_spacing got %0d exp 4", ld_cyc_a[b+1] - ld_cyc_a[b]); end
      checks++; if (ld_data_a[b+15] !== exp_grb(pix[15], 255)) begin errors++; $display("FAIL frame_pixel15 got %h exp %h", ld_data_a[b+15], exp_grb(pix[15], 255)); end
      checks++; if (ld_idx_a[b+15] !== 5'd15) begin errors++; $display("FAIL frame_pixel_index got %0d exp 15", ld_idx_a[b+15]); end
      checks++; if (n_load_a - b != 16) begin errors++; $display("FAIL frame_load_count got %0d exp 16", n_load_a - b); end
      checks++; if (n_latch_a - lb != 720) begin errors++; $display("FAIL frame_latch_cycles got %0d exp 720", n_latch_a - lb); end
      checks++; if (done_cyc_a - ld_cyc_a[b+15] != 722) begin errors++; $display("FAIL frame_done_timing got %0d exp 722", done_cyc_a - ld_cyc_a[b+15]); end
      steps(2);
      checks++; if (n_done_a - db != 1) begin errors++; $display("FAIL frame_done_count got %0d exp 1", n_done_a - db); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL frame_busy_fall got %b exp 0", busy_a); end
   endtask

   task automatic test_brightness();
      int c, b;
      bright = 8'd127;
      b = n_load_a;
      pulse_start_a(c);
      steps(10);
      bright = 8'd255;
      wait_done_a(n_done_a, 2000);
      checks++; if (ld_data_a[b] !== 24'h407F00) begin errors++; $display("FAIL bright127_pixel0 got %h exp 407f00", ld_data_a[b]); end
      checks++; if (ld_data_a[b+15] !== exp_grb(pix[15], 127)) begin errors++; $display("FAIL bright127_latched got %h exp %h", ld_data_a[b+15], exp_grb(pix[15], 127)); end
      steps(3);
      bright = 8'd0;
      b = n_load_a;
      pulse_start_a(c);
      wait_done_a(n_done_a, 2000);
      checks++; if (ld_data_a[b] !== 24'h000000) begin errors++; $display("FAIL bright0_pixel0 got %h exp 000000", ld_data_a[b]); end
      checks++; if (ld_data_a[b+9] !== 24'h000000) begin errors++; $display("FAIL bright0_pixel9 got %h exp 000000", ld_data_a[b+9]); end
      steps(3);
      bright = 8'd255;
   endtask

   task automatic test_pending();
      int c, b, db, d1;
      b = n_load_a; db = n_done_a;
      pulse_start_a(c);
      wait_loads_a(b + 1, 50);
      step();
      pulse_start_a(c);
      wait_done_a(db, 2000);
      d1 = done_cyc_a;
      checks++; if (n_load_a - b != 16) begin errors++; $display("FAIL pending_no_restart loads got %0d exp 16", n_load_a - b); end
      wait_done_a(db + 1, 2000);
      checks++; if (ld_cyc_a[b+16] - d1 != 4) begin errors++; $display("FAIL pending_restart_delay got %0d exp 4", ld_cyc_a[b+16] - d1); end
      checks++; if (ld_data_a[b+16] !== 24'h80FF01) begin errors++; $display("FAIL pending_pixel0 got %h exp 80ff01", ld_data_a[b+16]); end
      steps(40);
      checks++; if (n_done_a - db != 2 || busy_a !== 1'b0) begin errors++; $display("FAIL pending_single_queue frames %0d busy %b exp 2 0", n_done_a - db, busy_a); end
   endtask

   task automatic test_reset_mid();
      int c, b, lb, db;
      b = n_load_a;
      pulse_start_a(c);
      wait_loads_a(b + 6, 100);
      resp_en_a = 1'b0;
      checks++; if (ld_idx_a[b+5] !== 5'd5) begin errors++; $display("FAIL rstmid_index got %0d exp 5", ld_idx_a[b+5]); end
      step();
      lb = n_latch_a; db = n_done_a;
      rst_a = 1'b1;
      step();
      checks++; if (ifa.tx_load !== 1'b0 || busy_a !== 1'b0 || latch_a !== 1'b0) begin
         errors++; $display("FAIL rstmid_outputs load %b busy %b latch %b exp 0 0 0", ifa.tx_load, busy_a, latch_a); end
      checks++; if (pidx_a !== 5'd0) begin errors++; $display("FAIL rstmid_pixel_index got %0d exp 0", pidx_a); end
      rst_a = 1'b0;
      resp_en_a = 1'b1;
      steps(800);
      checks++; if (n_done_a != db || n_latch_a != lb) begin errors++; $display("FAIL rstmid_no_done done %0d latch %0d exp 0 0", n_done_a - db, n_latch_a - lb); end
      b = n_load_a;
      pulse_start_a(c);
      wait_done_a(db, 2000);
      checks++; if (ld_data_a[b] !== 24'h80FF01) begin errors++; $display("FAIL rstmid_ram_intact got %h exp 80ff01", ld_data_a[b]); end
      steps(3);
   endtask

   task automatic test_midwrite();
      int c, b, mism;
      b = n_load_a;
      pulse_start_a(c);
      wait_loads_a(b + 3, 50);
      step();
      write_pix(5'd3, 24'h00FF00);
      pix[3] = 24'h00FF00;
      wait_done_a(n_done_a, 2000);
      checks++; if (ld_data_a[b+3] !== 24'hFF0000) begin errors++; $display("FAIL midwrite_idx3 got %h exp ff0000", ld_data_a[b+3]); end
      steps(3);
      write_pix(5'd16, 24'h123456);
      b = n_load_a;
      pulse_start_a(c);
      wait_done_a(n_done_a, 2000);
      mism = 0;
      for (int i = 0; i < 16; i++) if (ld_data_a[b+i] !== exp_grb(pix[i], 255)) mism++;
      checks++; if (mism != 0) begin errors++; $display("FAIL oob_write_ignored mismatching words %0d exp 0 (pixel0 %h)", mism, ld_data_a[b]); end
      steps(3);
   endtask

   task automatic test_spurious();
      int c, b, lb, db;
      b = n_load_a;
      spur_a = 1'b1; step(); spur_a = 1'b0;
      steps(5);
      checks++; if (busy_a !== 1'b0 || n_load_a != b) begin errors++; $display("FAIL spurious_idle busy %b loads %0d exp 0 0", busy_a, n_load_a - b); end
      lb = n_latch_a; db = n_done_a;
      pulse_start_a(c);
      for (int i = 0; i < 200 && latch_a !== 1'b1; i++) step();
      steps(100);
      spur_a = 1'b1; step(); spur_a = 1'b0;
      wait_done_a(db, 2000);
      checks++; if (n_latch_a - lb != 720) begin errors++; $display("FAIL spurious_latch cycles got %0d exp 720", n_latch_a - lb); end
      checks++; if (n_load_a - b != 16) begin errors++; $display("FAIL spurious_loads got %0d exp 16", n_load_a - b); end
      steps(3);
   endtask

   task automatic test_refresh();
      int a, b, db;
      b = n_load_b; db = n_done_b;
      auto_b = 1'b1;
      a = cyc;
      steps(999);
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      steps(2100);
      auto_b = 1'b0;
      steps(800);
      checks++; if (n_done_b - db != 3) begin errors++; $display("FAIL refresh_frames got %0d exp 3", n_done_b - db); end
      checks++; if (n_load_b - b != 48) begin errors++; $display("FAIL refresh_loads got %0d exp 48", n_load_b - b); end
      checks++; if (ld_cyc_b[b] - a != 1002) begin errors++; $display("FAIL refresh_frame1_start got %0d exp 1002", ld_cyc_b[b] - a); end
      checks++; if (ld_cyc_b[b+16] - a != 2002) begin errors++; $display("FAIL refresh_frame2_start got %0d exp 2002", ld_cyc_b[b+16] - a); end
      checks++; if (ld_cyc_b[b+32] - a != 3002) begin errors++; $display("FAIL refresh_frame3_start got %0d exp 3002", ld_cyc_b[b+32] - a); end
      checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL refresh_idle busy got %b exp 0", busy_b); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) pix[i] = {8'(17*i + 5), 8'(250 - 9*i), 8'(13*i)};
      pix[0] = 24'hFF8001;
      test_reset();
      for (int i = 0; i < 16; i++) write_pix(5'(i), pix[i]);
      step();
      test_frame();
      test_brightness();
      test_pending();
      test_reset_mid();
      test_midwrite();
      test_spurious();
      test_refresh();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
